// File: rtl/score_board.sv
// score_board: per-player quiz scores (0..99) driven by answer edges, shown on a multiplexed 7-segment display.
// Optional win lock with winner dp is enabled by defining SCORE_WIN_LOCK_EN.
module score_board #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned CORRECT_PTS = 1,
  parameter int unsigned WRONG_PTS   = 1,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned WIN_SCORE   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_PLAYERS-1:0]   player,
  input  logic                     ifCorrect,
  input  logic                     ifWrong,
  output logic [7:0]               seg_out,
  output logic [2*NUM_PLAYERS-1:0] seg_en,
  output logic [3:0]               num,
  output logic                     winner
);

  localparam int unsigned NUM_DIGITS = 2 * NUM_PLAYERS;
  localparam int unsigned DW         = $clog2(NUM_DIGITS);
  localparam int unsigned DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0]  MAX_SCORE  = 7'd99;

  if (NUM_PLAYERS == 0 || NUM_PLAYERS > 8) begin : g_chk_players
    $error("score_board: NUM_PLAYERS must be 1..8");
  end
  if (CORRECT_PTS == 0 || CORRECT_PTS > 9 || WRONG_PTS == 0 || WRONG_PTS > 9) begin : g_chk_pts
    $error("score_board: CORRECT_PTS and WRONG_PTS must be 1..9");
  end
  if (SCAN_DIV == 0 || WIN_SCORE == 0 || WIN_SCORE > 99) begin : g_chk_misc
    $error("score_board: SCAN_DIV must be >= 1 and WIN_SCORE 1..99");
  end

  logic             corr_sync, corr_prev, wrong_sync, wrong_prev;
  logic [6:0]       score       [NUM_PLAYERS];
  logic [6:0]       score_nxt_c [NUM_PLAYERS];
  logic [DIV_W-1:0] div_cnt, div_nxt_c;
  logic [DW-1:0]    dig, dig_nxt_c;
  logic             hit_c, do_corr_c, do_wrong_c, lock_c, dp_c;
  logic [3:0]       num_c, digit_c;
  logic [NUM_DIGITS-1:0] seg_en_c;

  function automatic logic [6:0] seg_pat(input logic [3:0] v);
    case (v)
      4'd0:    seg_pat = 7'h40;
      4'd1:    seg_pat = 7'h79;
      4'd2:    seg_pat = 7'h24;
      4'd3:    seg_pat = 7'h30;
      4'd4:    seg_pat = 7'h19;
      4'd5:    seg_pat = 7'h12;
      4'd6:    seg_pat = 7'h02;
      4'd7:    seg_pat = 7'h78;
      4'd8:    seg_pat = 7'h00;
      4'd9:    seg_pat = 7'h10;
      default: seg_pat = 7'h7F;
    endcase
  endfunction

  // Edges qualify only with a single answering player; simultaneous correct/wrong cancel.
  always_comb begin
    hit_c      = enable && $onehot(player);
    do_corr_c  = hit_c && corr_sync && !corr_prev && !(wrong_sync && !wrong_prev);
    do_wrong_c = hit_c && wrong_sync && !wrong_prev && !(corr_sync && !corr_prev);
    num_c      = 4'd0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (hit_c && player[p]) num_c = 4'(p + 1);
    end
  end

  // Saturating score update for the selected player only.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      score_nxt_c[p] = score[p];
      if (player[p] && !lock_c) begin
        if (do_corr_c) begin
          score_nxt_c[p] = (({1'b0, score[p]} + 8'(CORRECT_PTS)) > {1'b0, MAX_SCORE}) ?
                           MAX_SCORE : 7'(score[p] + 7'(CORRECT_PTS));
        end else if (do_wrong_c) begin
          score_nxt_c[p] = (score[p] >= 7'(WRONG_PTS)) ? 7'(score[p] - 7'(WRONG_PTS)) : 7'd0;
        end
      end
    end
  end

`ifdef SCORE_WIN_LOCK_EN
  localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic [PW-1:0] win_idx, win_idx_c;
  logic          win_set_c;

  always_comb begin
    win_set_c = 1'b0;
    win_idx_c = win_idx;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (player[p] && (do_corr_c || do_wrong_c) && !winner &&
          score_nxt_c[p] >= 7'(WIN_SCORE)) begin
        win_set_c = 1'b1;
        win_idx_c = PW'(p);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      winner  <= 1'b0;
      win_idx <= '0;
    end else if (win_set_c) begin
      winner  <= 1'b1;
      win_idx <= win_idx_c;
    end
  end

  assign lock_c = winner;
`else
  assign winner = 1'b0;
  assign lock_c = 1'b0;
`endif

  // Scan divider, next digit and its segment pattern, so seg_en and seg_out move together.
  always_comb begin
    div_nxt_c = div_cnt + DIV_W'(1);
    dig_nxt_c = dig;
    if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_nxt_c = '0;
      dig_nxt_c = (dig == DW'(NUM_DIGITS - 1)) ? '0 : dig + DW'(1);
    end
    digit_c = 4'd0;
    dp_c    = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (dig_nxt_c == DW'(2 * p)) begin
        digit_c = 4'(score[p] % 7'd10);
`ifdef SCORE_WIN_LOCK_EN
        dp_c    = winner && (win_idx == PW'(p));
`endif
      end
      if (dig_nxt_c == DW'(2 * p + 1)) digit_c = 4'(score[p] / 7'd10);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_en_c[i] = (dig_nxt_c != DW'(i));
    end
  end

  // Edge pipes follow the live level during reset so a held input is not seen as a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_sync  <= ifCorrect;
      corr_prev  <= ifCorrect;
      wrong_sync <= ifWrong;
      wrong_prev <= ifWrong;
      for (int p = 0; p < NUM_PLAYERS; p++) score[p] <= '0;
      div_cnt    <= '0;
      dig        <= '0;
      num        <= '0;
      seg_en     <= {{(NUM_DIGITS - 1){1'b1}}, 1'b0};
      seg_out    <= 8'hC0;
    end else begin
      corr_sync  <= ifCorrect;
      corr_prev  <= corr_sync;
      wrong_sync <= ifWrong;
      wrong_prev <= wrong_sync;
      for (int p = 0; p < NUM_PLAYERS; p++) score[p] <= score_nxt_c[p];
      div_cnt    <= div_nxt_c;
      dig        <= dig_nxt_c;
      num        <= num_c;
      seg_en     <= seg_en_c;
      seg_out    <= {~dp_c, seg_pat(digit_c)};
    end
  end

endmodule

// File: tb/tb_score_board.sv
// tb_score_board: directed and random stimulus against an arithmetic model of score_board.
module tb_score_board;
  localparam int NP = 4;
  localparam int ND = 2 * NP;
  localparam int CP = 1;
  localparam int WP = 1;
  localparam int SD = 2;
  localparam int WS = 3;
`ifdef SCORE_WIN_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       ifCorrect = 1'b0;
  logic       ifWrong = 1'b0;
  logic [3:0] player = 4'd0;
  logic [7:0] seg_out;
  logic [7:0] seg_en;
  logic [3:0] num;
  logic       winner;

  int checks = 0;
  int errors = 0;

  logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [7:0] scan_tbl [16] = '{8'hFE, 8'hFE, 8'hFD, 8'hFD, 8'hFB, 8'hFB, 8'hF7, 8'hF7,
                                8'hEF, 8'hEF, 8'hDF, 8'hDF, 8'hBF, 8'hBF, 8'h7F, 8'h7F};

  always #5 clk = ~clk;

  score_board #(
    .NUM_PLAYERS(NP),
    .CORRECT_PTS(CP),
    .WRONG_PTS  (WP),
    .SCAN_DIV   (SD),
    .WIN_SCORE  (WS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .player   (player),
    .ifCorrect(ifCorrect),
    .ifWrong  (ifWrong),
    .seg_out  (seg_out),
    .seg_en   (seg_en),
    .num      (num),
    .winner   (winner)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scores as integers, digit position from elapsed cycles since reset.
  int         m_score [NP];
  bit         m_win, m_valid;
  int         m_widx, m_k, m_num;
  logic [7:0] m_seg_out, m_seg_en;
  bit         ch1, ch2, wh1, wh2, ce, we;
  int         dd, v, who;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_score[i]) m_score[i] = 0;
      m_win = 1'b0; m_widx = 0; m_k = 0; m_num = 0;
      m_seg_out = 8'hC0; m_seg_en = 8'hFE; m_valid = 1'b1;
      ch1 = ifCorrect; ch2 = ifCorrect; wh1 = ifWrong; wh2 = ifWrong;
    end else if (m_valid) begin
      m_k++;
      dd = (m_k / SD) % ND;
      m_seg_en = ~(8'(1) << dd);
      v = (dd % 2 == 0) ? m_score[dd / 2] % 10 : m_score[dd / 2] / 10;
      m_seg_out = pat[v];
      if (m_win && dd == 2 * m_widx) m_seg_out[7] = 1'b0;
      ce = ch1 && !ch2;
      we = wh1 && !wh2;
      who = -1;
      if (enable && $countones(player) == 1)
        for (int i = 0; i < NP; i++) if (player[i]) who = i;
      m_num = who + 1;
      if (who >= 0 && ce != we && !m_win) begin
        if (ce) m_score[who] = (m_score[who] + CP > 99) ? 99 : m_score[who] + CP;
        else    m_score[who] = (m_score[who] < WP) ? 0 : m_score[who] - WP;
`ifdef SCORE_WIN_LOCK_EN
        if (m_score[who] >= WS) begin m_win = 1'b1; m_widx = who; end
`endif
      end
      ch2 = ch1; ch1 = ifCorrect;
      wh2 = wh1; wh1 = ifWrong;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("seg_out", seg_out, m_seg_out);
      check("seg_en", seg_en, m_seg_en);
      check("num", 8'(num), 8'(m_num));
      check("winner", 8'(winner), 8'(m_win));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input bit c, input bit w);
    ifCorrect = c; ifWrong = w;
    repeat (2) @(negedge clk);
    ifCorrect = 1'b0; ifWrong = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic show_digit(input int d, input logic [7:0] exp, input string name);
    logic [7:0] want;
    bit found;
    want = ~(8'(1) << d);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (seg_en === want) begin
        found = 1'b1;
        check(name, seg_out, exp);
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: digit %0d never selected, seg_en %02h", name, d, seg_en);
    end
  endtask

  initial begin
    do_reset();
    check("rst seg_en", seg_en, 8'hFE);
    check("rst seg_out", seg_out, 8'hC0);
    check("rst num", 8'(num), 8'h00);
    check("rst winner", 8'(winner), 8'h00);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("scan seg_en", seg_en, scan_tbl[i]);
      check("scan seg_out", seg_out, 8'hC0);
    end

    enable = 1'b1; player = 4'b0001;
    repeat (6) pulse(1'b1, 1'b0);
    show_digit(0, LOCK ? 8'h30 : 8'h82, "p0 six ones");
    show_digit(1, 8'hC0, "p0 six tens");
    player = 4'b0010;
    pulse(1'b0, 1'b1);
    show_digit(2, 8'hC0, "p1 floor");
    check("num p1", 8'(num), 8'h02);

    enable = 1'b0;
    pulse(1'b1, 1'b0);
    check("num disabled", 8'(num), 8'h00);
    enable = 1'b1; player = 4'b0011;
    pulse(1'b1, 1'b0);
    check("num multihot", 8'(num), 8'h00);
    player = 4'b0001;
    pulse(1'b1, 1'b1);
    show_digit(0, LOCK ? 8'h30 : 8'h82, "p0 unchanged");

    do_reset();
    enable = 1'b1; player = 4'b0100;
    repeat (3) pulse(1'b1, 1'b0);
    check("winner at 3", 8'(winner), LOCK ? 8'h01 : 8'h00);
    show_digit(4, LOCK ? 8'h30 : 8'hB0, "p2 at 3");
    repeat (2) pulse(1'b1, 1'b0);
    show_digit(4, LOCK ? 8'h30 : 8'h92, "p2 after more");
    check("winner held", 8'(winner), LOCK ? 8'h01 : 8'h00);

    ifCorrect = 1'b1;
    do_reset();
    player = 4'b0001;
    repeat (4) @(negedge clk);
    ifCorrect = 1'b0;
    repeat (3) @(negedge clk);
    show_digit(0, 8'hC0, "held through rst");
    check("winner post rst", 8'(winner), 8'h00);

    repeat (102) pulse(1'b1, 1'b0);
    show_digit(0, LOCK ? 8'h30 : 8'h90, "sat ones");
    show_digit(1, LOCK ? 8'hC0 : 8'h90, "sat tens");

    do_reset();
    player = 4'b0001;
    repeat (2) pulse(1'b1, 1'b0);
    repeat (3) pulse(1'b0, 1'b1);
    show_digit(0, 8'hC0, "p0 floor");

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 9))
        7:       player = 4'd0;
        8, 9:    player = 4'($urandom_range(0, 15));
        default: player = 4'(1 << $urandom_range(0, 3));
      endcase
      ifCorrect = ($urandom_range(0, 2) == 0);
      ifWrong   = ($urandom_range(0, 3) == 0);
    end
    rst = 1'b0; ifCorrect = 1'b0; ifWrong = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
